key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 49 ++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: per-channel two-flop synchronizer and stability counter producing a debounced level with press/release pulses.
// Optional 8-bit press event counter on port press_cnt when KEY_DEBOUNCE_PRESS_CNT_EN is defined.
module key_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] key_pressed,
  output logic [WIDTH-1:0] key_released
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
  ,
  output logic [7:0]       press_cnt
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, s, st, accept;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    assign accept[i] = (s[i] != st[i]) && (cnt == CMAX);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (s[i] == st[i] || accept[i]) ? '0 : cnt + CW'(1);
  end
  // st holds raw polarity, so flipping it on accept adopts the synchronized level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1        <= '1;
      s            <= '1;
      st           <= '1;
      key_pressed  <= '0;
      key_released <= '0;
    end else begin
      sync1        <= key_raw;
      s            <= sync1;
      st           <= st ^ accept;
      key_pressed  <= accept & ~s;
      key_released <= accept & s;
    end
  assign key = ~st;
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) press_cnt <= '0;
    else press_cnt <= press_cnt + 8'(|key_pressed);
`endif
endmodule
